// File: rtl/lm07_spi_responder.sv
// LM07 temperature sensor SPI responder (sensor side of the read link).
// CS and SCK are asynchronous to SYSCLK, so both are oversampled through
// synchroniser chains and their edges are detected against one extra flop.
// While CS is low, a 16-bit frame {temperature, 2'b11, fresh} is shifted
// out on SIO MSB-first. SIO changes after each detected SCK fall, so it is
// stable when the initiator samples on the SCK rise.
module lm07_spi_responder #(
  parameter int TEMP_W      = 13,
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCK,
  input  logic [TEMP_W-1:0] TEMP_IN,
  input  logic              TEMP_VALID,
  output logic              SIO,
  output logic              SIO_OE,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Input synchronisers and edge-detect history.
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic                   cs_prev_q;
  logic                   sck_prev_q;

  // Holding register for the most recent temperature code.
  logic [TEMP_W-1:0]      hold_q;
  logic                   fresh_q;

  // Frame engine state and registered outputs.
  state_t                 state_q;
  logic [FRAME_W-1:0]     shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   sio_q;
  logic                   sio_oe_q;
  logic                   busy_q;
  logic                   frame_done_q;

  // Derived, combinational helpers.
  logic                   cs_s;
  logic                   sck_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_fall;
  logic                   sck_rise;
  logic [FRAME_W-1:0]     frame_d;
  logic [CNT_W-1:0]       bit_cnt_d;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_fall  =  cs_prev_q  & ~cs_s;
  assign cs_rise  = ~cs_prev_q  &  cs_s;
  assign sck_fall =  sck_prev_q & ~sck_s;
  assign sck_rise = ~sck_prev_q &  sck_s;

  // Frame image built from the current (pre-update) holding register, so a
  // strobe coinciding with the CS fall lands in the next frame, not this one.
  assign frame_d   = {hold_q, 2'b11, fresh_q};
  assign bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;

  // Two-flop (or deeper) synchronisers for CS/SCK plus one history flop each.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  // Capture new temperature codes only while idle; a strobe wins over the
  // fresh-clear caused by a simultaneous CS fall.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      hold_q  <= '0;
      fresh_q <= 1'b0;
    end else if (TEMP_VALID && state_q == ST_IDLE) begin
      hold_q  <= TEMP_IN;
      fresh_q <= 1'b1;
    end else if (cs_fall && state_q == ST_IDLE) begin
      fresh_q <= 1'b0;
    end
  end

  // Frame FSM: load on CS fall, shift on SCK fall, finish on 16th SCK rise.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sio_q        <= 1'b0;
      sio_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (cs_rise) begin
        state_q   <= ST_IDLE;
        sio_q     <= 1'b0;
        sio_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              shift_q   <= frame_d;
              sio_q     <= frame_d[FRAME_W-1];
              sio_oe_q  <= 1'b1;
              busy_q    <= 1'b1;
              bit_cnt_q <= CNT_W'(1);
              state_q   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (sck_fall) begin
              shift_q   <= shift_q << 1;
              sio_q     <= shift_q[FRAME_W-2];
              bit_cnt_q <= bit_cnt_d;
            end else if (sck_rise && bit_cnt_q == CNT_MAX) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (sck_fall) begin
              sio_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign SIO        = sio_q;
  assign SIO_OE     = sio_oe_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_lm07_spi_responder.sv
// Scoreboard bench for lm07_spi_responder. Stimulus pushes the expected SIO
// bit for every SCK rise and the expected FRAME_DONE events; monitors pop
// and compare whenever the initiator samples or the DUT pulses FRAME_DONE.
module tb_lm07_spi_responder;

  localparam int HALF = 4;  // SCK half period in SYSCLK cycles

  logic        sysclk = 1'b0;
  logic        rst    = 1'b1;
  logic        cs     = 1'b1;
  logic        sck    = 1'b0;
  logic [12:0] temp_in = '0;
  logic        temp_valid = 1'b0;
  logic        sio;
  logic        sio_oe;
  logic        busy;
  logic        frame_done;

  typedef struct {
    string tag;
    logic  oe;
    logic  sio;
  } exp_bit_t;

  exp_bit_t sb_q[$];
  int       done_q[$];
  int       checks   = 0;
  int       failures = 0;
  int       rise_cnt = 0;

  lm07_spi_responder #(
    .TEMP_W(13),
    .FRAME_W(16),
    .SYNC_STAGES(2)
  ) dut (
    .SYSCLK    (sysclk),
    .RST       (rst),
    .CS        (cs),
    .SCK       (sck),
    .TEMP_IN   (temp_in),
    .TEMP_VALID(temp_valid),
    .SIO       (sio),
    .SIO_OE    (sio_oe),
    .BUSY      (busy),
    .FRAME_DONE(frame_done)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic strobe(input logic [12:0] v);
    temp_in    = v;
    temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(6);
    check("busy_after_cs_fall", {31'd0, busy}, 32'd1);
  endtask

  // SIO_OE must drop within SYNC_STAGES+1 cycles of the CS rise.
  task automatic cs_high();
    cs = 1'b1;
    tick(3);
    check("oe_off_after_cs_rise", {31'd0, sio_oe}, 32'd0);
    check("busy_off_after_cs_rise", {31'd0, busy}, 32'd0);
    tick(3);
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] f, input int nbits,
                              input int nzeros, input bit done);
    exp_bit_t e;
    for (int i = 0; i < nbits; i++) begin
      e.tag = $sformatf("%s_bit%0d", tag, 15 - i);
      e.oe  = 1'b1;
      e.sio = f[15-i];
      sb_q.push_back(e);
    end
    for (int i = 0; i < nzeros; i++) begin
      e.tag = $sformatf("%s_zero%0d", tag, i);
      e.oe  = 1'b1;
      e.sio = 1'b0;
      sb_q.push_back(e);
    end
    if (done) done_q.push_back(16);
  endtask

  task automatic expect_idle_rises(input string tag, input int n);
    exp_bit_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = $sformatf("%s_%0d", tag, i);
      e.oe  = 1'b0;
      e.sio = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  // Initiator-side monitor: samples SIO/SIO_OE at every SCK rise.
  initial begin : sio_monitor
    logic     cs_last;
    logic     sck_last;
    exp_bit_t e;
    cs_last  = 1'b1;
    sck_last = 1'b0;
    forever begin
      @(sck or cs);
      if (!cs && cs_last) rise_cnt = 0;
      if (sck && !sck_last) begin
        if (!cs) rise_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sck_rise actual=sio%0b/oe%0b required=none @%0t",
                   sio, sio_oe, $time);
        end else begin
          e = sb_q.pop_front();
          check({e.tag, "_oe"}, {31'd0, sio_oe}, {31'd0, e.oe});
          check({e.tag, "_sio"}, {31'd0, sio}, {31'd0, e.sio});
        end
      end
      cs_last  = cs;
      sck_last = sck;
    end
  end

  // FRAME_DONE monitor: each pulse must match an expected completed frame
  // and arrive after the 16th SCK rise of that CS window.
  initial begin : done_monitor
    int exp_rise;
    forever begin
      @(negedge sysclk);
      if (frame_done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_done actual=pulse required=none @%0t", $time);
        end else begin
          exp_rise = done_q.pop_front();
          check("frame_done_rise_idx", rise_cnt, exp_rise);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state.
    tick(3);
    check("rst_sio", {31'd0, sio}, 32'd0);
    check("rst_oe", {31'd0, sio_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    tick(4);

    // 1: 25 C strobed in idle, full read.
    strobe(13'h0190);
    tick(2);
    expect_frame("t1", 16'h0C87, 16, 0, 1'b1);
    cs_low();
    clocks(16);
    cs_high();

    // 2: no new strobe, fresh now clear.
    expect_frame("t2", 16'h0C86, 16, 0, 1'b1);
    cs_low();
    clocks(16);
    cs_high();

    // 3: -10 C, aborted after 8 bits, then a full stale read.
    strobe(13'h1F60);
    tick(2);
    expect_frame("t3a", 16'hFB07, 8, 0, 1'b0);
    cs_low();
    clocks(8);
    cs_high();
    expect_frame("t3b", 16'hFB06, 16, 0, 1'b1);
    cs_low();
    clocks(16);
    cs_high();

    // 4: strobe during a frame is dropped.
    expect_frame("t4a", 16'hFB06, 16, 0, 1'b1);
    cs_low();
    clocks(8);
    strobe(13'h0050);
    clocks(8);
    cs_high();
    expect_frame("t4b", 16'hFB06, 16, 0, 1'b1);
    cs_low();
    clocks(16);
    cs_high();

    // 5: 20 clocks in one window, then SCK toggling with CS high.
    strobe(13'h0190);
    tick(2);
    expect_frame("t5", 16'h0C87, 16, 4, 1'b1);
    cs_low();
    clocks(20);
    cs_high();
    expect_idle_rises("t5_cs_high", 3);
    clocks(3);
    tick(4);

    // 7: strobe lands in the same cycle the CS fall is seen.
    expect_frame("t7a", 16'h0C86, 16, 0, 1'b1);
    cs = 1'b0;
    tick(2);
    temp_in    = 13'h0A5A;
    temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    tick(3);
    check("t7_busy", {31'd0, busy}, 32'd1);
    clocks(16);
    cs_high();
    expect_frame("t7b", 16'h52D7, 16, 0, 1'b1);
    cs_low();
    clocks(16);
    cs_high();

    // 6: reset at bit 5, then restart with cleared holding register.
    expect_frame("t6a", 16'h52D6, 5, 0, 1'b0);
    cs_low();
    clocks(5);
    rst = 1'b1;
    tick(1);
    check("t6_rst_sio", {31'd0, sio}, 32'd0);
    check("t6_rst_oe", {31'd0, sio_oe}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, frame_done}, 32'd0);
    cs = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    expect_frame("t6b", 16'h0006, 16, 0, 1'b1);
    cs_low();
    clocks(16);
    cs_high();

    tick(10);
    check("sb_bits_drained", sb_q.size(), 32'd0);
    check("sb_done_drained", done_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
